// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared constants and state type for the MAC operand loader
package mac_pkg;

    localparam int DATA_W      = 32;
    localparam int N_LANES     = 16;
    localparam int IDX_W       = 4;
    localparam int TIMEOUT     = 15;
    localparam int MAC_LATENCY = 6;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/mac_16_operand_loader.sv
// rtl/mac_16_operand_loader.sv - packs 16 operands, runs the MAC job, hands the result downstream
module mac_16_operand_loader
    import mac_pkg::*;
#(
    parameter int DATA_W_P  = DATA_W,
    parameter int N_LANES_P = N_LANES,
    parameter int IDX_W_P   = IDX_W,
    parameter int TIMEOUT_P = TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_W_P-1:0]           in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [N_LANES_P*DATA_W_P-1:0] lanes,
    output logic                          mac_start,
    input  logic                          mac_valid,
    input  logic [DATA_W_P-1:0]           mac_result,
    output logic [DATA_W_P-1:0]           out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          err
);

    localparam int WDOG_W = $clog2(TIMEOUT_P);

    state_t                state_q, state_d;
    logic [IDX_W_P-1:0]    idx_q, idx_d;
    logic [WDOG_W-1:0]     wdog_q, wdog_d;
    logic                  err_q, err_d;
    logic [DATA_W_P-1:0]   out_data_q, out_data_d;
    logic [DATA_W_P-1:0]   lanes_q [N_LANES_P];
    logic [DATA_W_P-1:0]   lanes_d [N_LANES_P];

    // Next-state logic: lane fill, MAC wait with watchdog, result drain
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wdog_d     = wdog_q;
        err_d      = err_q;
        out_data_d = out_data_q;
        lanes_d    = lanes_q;
        case (state_q)
            FILL: begin
                if (in_valid) begin
                    lanes_d[idx_q] = in_data;
                    if (idx_q == IDX_W_P'(N_LANES_P - 1)) begin
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (mac_valid) begin
                    out_data_d = mac_result;
                    wdog_d     = '0;
                    state_d    = DRAIN;
                end else if (wdog_q == WDOG_W'(TIMEOUT_P - 1)) begin
                    // The MAC never answered: drop the job and flag it until reset
                    err_d   = 1'b1;
                    wdog_d  = '0;
                    state_d = FILL;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State registers; reset discards any partially filled job
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FILL;
            idx_q      <= '0;
            wdog_q     <= '0;
            err_q      <= 1'b0;
            out_data_q <= '0;
            for (int k = 0; k < N_LANES_P; k++) begin
                lanes_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wdog_q     <= wdog_d;
            err_q      <= err_d;
            out_data_q <= out_data_d;
            lanes_q    <= lanes_d;
        end
    end

    // Handshake and control outputs decode from state only
    assign in_ready  = (state_q == FILL);
    assign mac_start = (state_q == RUN);
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign err       = err_q;
    assign out_data  = out_data_q;

    for (genvar g = 0; g < N_LANES_P; g++) begin : g_lanes
        assign lanes[g*DATA_W_P +: DATA_W_P] = lanes_q[g];
    end

endmodule

// File: tb/tb_mac_16_operand_loader.sv
// tb/tb_mac_16_operand_loader.sv - directed and randomized checks of the MAC operand loader
module tb_mac_16_operand_loader;
    import mac_pkg::*;

    logic                        clk;
    logic                        reset;
    logic [DATA_W-1:0]           in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [N_LANES*DATA_W-1:0]   lanes;
    logic                        mac_start;
    logic                        mac_valid;
    logic [DATA_W-1:0]           mac_result;
    logic [DATA_W-1:0]           out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        busy;
    logic                        err;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] job_words [N_LANES];
    logic [DATA_W-1:0] exp_lanes [N_LANES];
    logic              exp_err;

    mac_16_operand_loader dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .lanes      (lanes),
        .mac_start  (mac_start),
        .mac_valid  (mac_valid),
        .mac_result (mac_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lanes(input string tag);
        for (int k = 0; k < N_LANES; k++) begin
            chk($sformatf("%s_lane%0d", tag, k), lanes[k*DATA_W +: DATA_W], exp_lanes[k]);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < N_LANES; k++) exp_lanes[k] = '0;
        exp_err = 1'b0;
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps; noisy mac_valid while filling
    task automatic feed_job(input int mode, input string tag);
        int n = 0;
        int cyc = 0;
        logic v;
        while (n < N_LANES) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = $urandom_range(0, 1) == 1;
            endcase
            in_valid   = v;
            in_data    = v ? job_words[n] : $urandom;
            mac_valid  = (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
            mac_result = $urandom;
            chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
            chk({tag, "_start_low"}, {31'b0, mac_start}, 32'd0);
            tick();
            if (v) n++;
            cyc++;
        end
        in_valid  = 1'b0;
        mac_valid = 1'b0;
        for (int k = 0; k < N_LANES; k++) exp_lanes[k] = job_words[k];
        chk({tag, "_start_high"}, {31'b0, mac_start}, 32'd1);
        chk({tag, "_busy_run"}, {31'b0, busy}, 32'd1);
        chk({tag, "_in_ready_run"}, {31'b0, in_ready}, 32'd0);
        chk_lanes(tag);
    endtask

    // MAC answers MAC_LATENCY cycles after start; upstream pushes junk to prove it is held off
    task automatic run_mac(input logic [DATA_W-1:0] res, input int hold, input string tag);
        logic [DATA_W-1:0] junk;
        junk = $urandom;
        in_valid = 1'b1;
        in_data  = junk;
        for (int c = 1; c < MAC_LATENCY; c++) begin
            tick();
            chk({tag, "_wait_start"}, {31'b0, mac_start}, 32'd1);
            chk({tag, "_wait_ov"}, {31'b0, out_valid}, 32'd0);
        end
        tick();
        mac_valid  = 1'b1;
        mac_result = res;
        tick();
        mac_valid  = 1'b0;
        mac_result = $urandom;
        for (int c = 0; c <= hold; c++) begin
            chk({tag, "_ov"}, {31'b0, out_valid}, 32'd1);
            chk({tag, "_od"}, out_data, res);
            chk({tag, "_start_drain"}, {31'b0, mac_start}, 32'd0);
            chk({tag, "_busy_drain"}, {31'b0, busy}, 32'd1);
            chk({tag, "_in_ready_drain"}, {31'b0, in_ready}, 32'd0);
            if (c < hold) tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_fill_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_fill_ov"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_fill_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        chk_lanes({tag, "_frozen"});
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_valid = 1'b0; mac_valid = 1'b0;
        mac_result = '0; out_ready = 1'b0;
        tick();
        do_reset();

        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_start", {31'b0, mac_start}, 32'd0);
        chk("rst_ov", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_od", out_data, 32'd0);
        chk_lanes("rst");

        for (int k = 0; k < N_LANES; k++) job_words[k] = DATA_W'(k + 1);
        feed_job(0, "t1");
        run_mac(32'h0000_0088, 5, "t2");

        for (int k = 0; k < N_LANES; k++) job_words[k] = DATA_W'(32'hA0 + k);
        feed_job(1, "t4");
        chk("t4_lane15", lanes[15*DATA_W +: DATA_W], 32'hAF);
        run_mac($urandom, 0, "t4r");

        for (int k = 0; k < N_LANES; k++) job_words[k] = $urandom;
        feed_job(2, "t5");
        for (int c = 1; c < TIMEOUT; c++) begin
            tick();
            chk("t5_wait_start", {31'b0, mac_start}, 32'd1);
            chk("t5_wait_err", {31'b0, err}, 32'd0);
        end
        tick();
        exp_err = 1'b1;
        chk("t5_err", {31'b0, err}, 32'd1);
        chk("t5_start", {31'b0, mac_start}, 32'd0);
        chk("t5_in_ready", {31'b0, in_ready}, 32'd1);
        chk("t5_ov", {31'b0, out_valid}, 32'd0);
        chk("t5_busy", {31'b0, busy}, 32'd0);

        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < N_LANES; k++) job_words[k] = $urandom;
            feed_job(2, $sformatf("rnd%0d", j));
            run_mac($urandom, $urandom_range(0, 4), $sformatf("rnd%0d", j));
        end
        chk("t5_err_sticky", {31'b0, err}, 32'd1);

        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            tick();
        end
        in_valid = 1'b0;
        do_reset();
        chk("t6_err_cleared", {31'b0, err}, 32'd0);
        chk("t6_in_ready", {31'b0, in_ready}, 32'd1);
        chk_lanes("t6_rst");

        for (int k = 0; k < N_LANES; k++) job_words[k] = DATA_W'(32'hB0 + k);
        feed_job(0, "t6");
        chk("t6_lane0", lanes[DATA_W-1:0], 32'hB0);
        tick();
        do_reset();
        chk("t6_run_rst_start", {31'b0, mac_start}, 32'd0);
        chk("t6_run_rst_busy", {31'b0, busy}, 32'd0);
        chk("t6_run_rst_ready", {31'b0, in_ready}, 32'd1);
        chk_lanes("t6_run_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
